// File: rtl/miner_pkg.sv
// Shared types and widths for the nonce sweep / SHA front end.
package miner_pkg;

    localparam int NONCE_W  = 32;
    localparam int MSG_W    = 440;
    localparam int HASH_W   = 256;
    localparam int PREFIX_W = MSG_W - NONCE_W;

    typedef logic [NONCE_W-1:0] nonce_t;
    typedef logic [HASH_W-1:0]  hash_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CHECK
    } sweep_state_t;

endpackage

// File: rtl/hash_target_compare.sv
// Unsigned strict less-than between a hash and a target; a zero target never hits.
module hash_target_compare
    import miner_pkg::*;
(
    input  logic [HASH_W-1:0] a,
    input  logic [HASH_W-1:0] b,
    output logic              lt
);

    assign lt = (a < b);

endmodule

// File: rtl/nonce_sweep_controller.sv
// Sweeps a nonce over an inclusive (wrapping) range, launching one SHA job per
// nonce and stopping on a hit, range end, watchdog expiry or abort.
module nonce_sweep_controller
    import miner_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic                abort,
    input  logic [PREFIX_W-1:0] header_prefix,
    input  logic [NONCE_W-1:0]  nonce_start,
    input  logic [NONCE_W-1:0]  nonce_end,
    input  logic [HASH_W-1:0]   target,
    output logic [MSG_W-1:0]    sha_msg,
    output logic                sha_begin,
    input  logic                sha_done,
    input  logic [HASH_W-1:0]   sha_hash,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output logic                timeout_err,
    output logic [NONCE_W-1:0]  result_nonce,
    output logic [HASH_W-1:0]   result_hash,
    output logic [31:0]         attempts
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    sweep_state_t        r_state;
    sweep_state_t        w_next;

    logic [PREFIX_W-1:0] r_prefix;
    nonce_t              r_nonce;
    nonce_t              r_nonce_end;
    hash_t               r_target;
    nonce_t              r_result_nonce;
    hash_t               r_result_hash;
    logic [WD_W-1:0]     r_wdog;
    logic                r_found;
    logic                r_exhausted;
    logic                r_timeout;
    logic [31:0]         r_attempts;

    logic                w_capture;
    logic                w_launch;
    logic                w_wd_run;
    logic                w_take;
    logic                w_timeout;
    logic                w_check;
    logic                w_hit;
    logic                w_last_nonce;

    hash_target_compare u_cmp (
        .a  (r_result_hash),
        .b  (r_target),
        .lt (w_hit)
    );

    assign w_last_nonce = (r_nonce == r_nonce_end);

    // State register.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state strobes; abort overrides everything.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_launch  = 1'b0;
        w_wd_run  = 1'b0;
        w_take    = 1'b0;
        w_timeout = 1'b0;
        w_check   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_capture = 1'b1;
                    w_next    = LAUNCH;
                end
            end
            LAUNCH: begin
                if (abort) begin
                    w_next = IDLE;
                end else begin
                    w_launch = 1'b1;
                    w_next   = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (sha_done) begin
                    w_take = 1'b1;
                    w_next = CHECK;
                end else if (r_wdog == WD_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end else begin
                    w_wd_run = 1'b1;
                end
            end
            CHECK: begin
                if (abort) begin
                    w_next = IDLE;
                end else begin
                    w_check = 1'b1;
                    if (w_hit || w_last_nonce) begin
                        w_next = IDLE;
                    end else begin
                        w_next = LAUNCH;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Sweep context, watchdog, results and sticky status flags.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_prefix       <= '0;
            r_nonce        <= '0;
            r_nonce_end    <= '0;
            r_target       <= '0;
            r_result_nonce <= '0;
            r_result_hash  <= '0;
            r_wdog         <= '0;
            r_found        <= 1'b0;
            r_exhausted    <= 1'b0;
            r_timeout      <= 1'b0;
            r_attempts     <= '0;
        end else begin
            if (w_capture) begin
                r_prefix    <= header_prefix;
                r_nonce     <= nonce_start;
                r_nonce_end <= nonce_end;
                r_target    <= target;
                r_found     <= 1'b0;
                r_exhausted <= 1'b0;
                r_timeout   <= 1'b0;
                r_attempts  <= '0;
            end
            if (w_launch) begin
                r_wdog <= '0;
            end else if (w_wd_run) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_take) begin
                r_result_hash  <= sha_hash;
                r_result_nonce <= r_nonce;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end
            if (w_check) begin
                if (r_attempts != 32'hFFFF_FFFF) begin
                    r_attempts <= r_attempts + 32'd1;
                end
                if (w_hit) begin
                    r_found <= 1'b1;
                end else if (w_last_nonce) begin
                    r_exhausted <= 1'b1;
                end else begin
                    r_nonce <= r_nonce + 1'b1;
                end
            end
        end
    end

    assign sha_msg      = {r_prefix, r_nonce};
    assign sha_begin    = w_launch;
    assign busy         = (r_state != IDLE);
    assign found        = r_found;
    assign exhausted    = r_exhausted;
    assign timeout_err  = r_timeout;
    assign result_nonce = r_result_nonce;
    assign result_hash  = r_result_hash;
    assign attempts     = r_attempts;

endmodule

// File: tb/tb_nonce_sweep_controller.sv
// Bench for nonce_sweep_controller: SHA stub with programmable latency/hash,
// directed table, randomized sweeps against a range-scan model, corner sequences.
module tb_nonce_sweep_controller;
    import miner_pkg::*;

    localparam int TO_SHORT = 16;
    localparam int TO_LONG  = 1024;

    logic                clk = 1'b0;
    logic                n_rst, start, abort, sha_done;
    logic [PREFIX_W-1:0] header_prefix;
    nonce_t              nonce_start, nonce_end;
    hash_t               target, sha_hash;

    logic [MSG_W-1:0]    sha_msg, s_sha_msg;
    logic                sha_begin, busy, found, exhausted, timeout_err;
    logic                s_sha_begin, s_busy, s_found, s_exhausted, s_timeout_err;
    nonce_t              result_nonce, s_result_nonce;
    hash_t               result_hash, s_result_hash;
    logic [31:0]         attempts, s_attempts;

    nonce_sweep_controller u_dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .header_prefix(header_prefix), .nonce_start(nonce_start), .nonce_end(nonce_end),
        .target(target), .sha_msg(sha_msg), .sha_begin(sha_begin), .sha_done(sha_done),
        .sha_hash(sha_hash), .busy(busy), .found(found), .exhausted(exhausted),
        .timeout_err(timeout_err), .result_nonce(result_nonce), .result_hash(result_hash),
        .attempts(attempts)
    );

    nonce_sweep_controller #(.TIMEOUT(TO_SHORT)) u_dut_to (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .header_prefix(header_prefix), .nonce_start(nonce_start), .nonce_end(nonce_end),
        .target(target), .sha_msg(s_sha_msg), .sha_begin(s_sha_begin), .sha_done(sha_done),
        .sha_hash(sha_hash), .busy(s_busy), .found(s_found), .exhausted(s_exhausted),
        .timeout_err(s_timeout_err), .result_nonce(s_result_nonce), .result_hash(s_result_hash),
        .attempts(s_attempts)
    );

    always #5 clk = ~clk;

    int unsigned stub_lat;
    int          stub_mode;
    nonce_t      stub_hit;
    hash_t       stub_const;
    logic [31:0] stub_salt;

    int     checks = 0;
    int     errors = 0;
    nonce_t got_q[$];

    // Model outputs
    logic   m_found, m_exh;
    int     m_att;
    nonce_t m_rn;
    hash_t  m_rh;

    typedef struct {
        nonce_t ns;
        nonce_t ne;
        hash_t  tgt;
        int     mode;
        nonce_t hit;
        hash_t  cst;
        int     lat;
        logic   ef;
        logic   ee;
        int     ea;
        nonce_t ern;
    } vec_t;

    vec_t tbl[6];

    function automatic hash_t hash_of(input nonce_t n);
        hash_t h;
        case (stub_mode)
            0:       h = stub_const;
            1:       h = (n == stub_hit) ? '0 : '1;
            default: h = {(n * 32'h9E37_79B1) ^ stub_salt, {7{n ^ stub_salt}}};
        endcase
        return h;
    endfunction

    function automatic hash_t rand_hash();
        hash_t h;
        for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
        return h;
    endfunction

    function automatic logic [PREFIX_W-1:0] rand_pfx();
        logic [PREFIX_W-1:0] p;
        for (int i = 0; i < 12; i++) p[i*32 +: 32] = $urandom;
        p[407:384] = 24'($urandom);
        return p;
    endfunction

    // SHA stub: answers each sha_begin after stub_lat cycles; junk hash otherwise.
    initial begin : stub
        int unsigned cnt;
        nonce_t      pn;
        cnt = 0;
        pn = '0;
        sha_done = 1'b0;
        sha_hash = '0;
        forever begin
            @(posedge clk);
            #1;
            sha_done = 1'b0;
            sha_hash = rand_hash();
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    sha_done = 1'b1;
                    sha_hash = hash_of(pn);
                end
            end
            if (sha_begin) begin
                pn  = sha_msg[NONCE_W-1:0];
                cnt = stub_lat;
            end
        end
    end

    task automatic chk(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: cycle bound expired with busy still 1, expected 0", name);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_msg"}, sha_msg, '0);
        chk({tag, "_begin"}, sha_begin, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_found"}, found, 0);
        chk({tag, "_exh"}, exhausted, 0);
        chk({tag, "_to"}, timeout_err, 0);
        chk({tag, "_rn"}, result_nonce, 0);
        chk({tag, "_rh"}, result_hash, 0);
        chk({tag, "_att"}, attempts, 0);
        chk({tag, "_s_busy"}, s_busy, 0);
        chk({tag, "_s_rh"}, s_result_hash, 0);
    endtask

    // Present a sweep request for one cycle, then scramble the inputs.
    task automatic start_both(input logic [PREFIX_W-1:0] pfx, input nonce_t ns, input nonce_t ne,
                              input hash_t tgt);
        @(negedge clk);
        header_prefix = pfx;
        nonce_start   = ns;
        nonce_end     = ne;
        target        = tgt;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        header_prefix = rand_pfx();
        nonce_start   = $urandom;
        nonce_end     = $urandom;
        target        = rand_hash();
    endtask

    task automatic wait_idle(input bit short_dut, input int budget, output int c);
        c = 0;
        while ((short_dut ? s_busy : busy) && c < budget) begin
            c++;
            @(negedge clk);
        end
        if (short_dut ? s_busy : busy) fail_bound(short_dut ? "wait_idle_short" : "wait_idle");
    endtask

    task automatic do_sweep(input logic [PREFIX_W-1:0] pfx, input nonce_t ns, input nonce_t ne,
                            input hash_t tgt, input int budget);
        int c;
        bit pbad;
        got_q.delete();
        pbad = 0;
        start_both(pfx, ns, ne, tgt);
        chk("begin_after_start", sha_begin, 1);
        chk("clr_found", found, 0);
        chk("clr_exh", exhausted, 0);
        chk("clr_to", timeout_err, 0);
        chk("clr_att", attempts, 0);
        c = 0;
        while (busy && c < budget) begin
            if (sha_begin) begin
                got_q.push_back(sha_msg[NONCE_W-1:0]);
                if (sha_msg[MSG_W-1:NONCE_W] !== pfx) pbad = 1;
            end
            @(negedge clk);
            c++;
        end
        if (busy) fail_bound("sweep");
        chk("prefix_in_msg", pbad, 0);
    endtask

    task automatic check_result(input string tag, input logic ef, input logic ee, input int ea,
                                input nonce_t ern, input hash_t erh, input nonce_t ns);
        int n;
        chk({tag, "_found"}, found, ef);
        chk({tag, "_exh"}, exhausted, ee);
        chk({tag, "_to"}, timeout_err, 0);
        chk({tag, "_att"}, attempts, ea);
        chk({tag, "_rn"}, result_nonce, ern);
        chk({tag, "_rh"}, result_hash, erh);
        chk({tag, "_nbegin"}, got_q.size(), ea);
        n = (got_q.size() < ea) ? got_q.size() : ea;
        for (int k = 0; k < n; k++) begin
            nonce_t e;
            e = ns + nonce_t'(k);
            chk($sformatf("%s_seq%0d", tag, k), got_q[k], e);
        end
    endtask

    // Reference: scan the range in order until a hash beats the target or the end is reached.
    task automatic model(input nonce_t ns, input nonce_t ne, input hash_t tgt);
        nonce_t n;
        n = ns;
        m_found = 0;
        m_exh = 0;
        m_att = 0;
        for (int guard = 0; guard < 1000; guard++) begin
            m_att++;
            m_rn = n;
            m_rh = hash_of(n);
            if (m_rh < tgt) begin
                m_found = 1;
                break;
            end
            if (n == ne) begin
                m_exh = 1;
                break;
            end
            n = n + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        n_rst = 1'b0;
    endtask

    initial begin
        int c, nb;
        hash_t h;
        logic [PREFIX_W-1:0] pfx;

        n_rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        header_prefix = '0;
        nonce_start = '0;
        nonce_end = '0;
        target = '0;
        stub_lat = 4;
        stub_mode = 0;
        stub_const = '0;
        stub_hit = '0;
        stub_salt = '0;

        repeat (3) @(negedge clk);
        chk_zero("rst_hold");
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("post_rst");

        //          ns            ne            tgt           mode hit  cst          lat ef ee ea ern
        tbl[0] = '{32'h5,        32'h5,        '1,           0,   0,   256'h1,      70, 1, 0, 1, 32'h5};
        tbl[1] = '{32'h10,       32'h13,       '0,           0,   0,   256'h0,      4,  0, 1, 4, 32'h13};
        tbl[2] = '{32'hFFFFFFFE, 32'h1,        256'h1,       1,   0,   256'h0,      3,  1, 0, 3, 32'h0};
        tbl[3] = '{32'h7,        32'h9,        256'h100,     0,   0,   256'h100,    2,  0, 1, 3, 32'h9};
        tbl[4] = '{32'h7,        32'h9,        256'h101,     0,   0,   256'h100,    1,  1, 0, 1, 32'h7};
        tbl[5] = '{32'hFFFFFFFF, 32'h0,        256'h1,       1,   5,   256'h0,      2,  0, 1, 2, 32'h0};

        for (int i = 0; i < 6; i++) begin
            stub_lat   = tbl[i].lat;
            stub_mode  = tbl[i].mode;
            stub_hit   = tbl[i].hit;
            stub_const = tbl[i].cst;
            pfx = (i == 0) ? '0 : rand_pfx();
            do_sweep(pfx, tbl[i].ns, tbl[i].ne, tbl[i].tgt, (tbl[i].ea + 1) * (tbl[i].lat + 4) + 20);
            check_result($sformatf("v%0d", i), tbl[i].ef, tbl[i].ee, tbl[i].ea, tbl[i].ern,
                         hash_of(tbl[i].ern), tbl[i].ns);
        end

        // Randomized sweeps against the range-scan model.
        for (int i = 0; i < 20; i++) begin
            nonce_t ns, ne;
            hash_t  tgt;
            int     len;
            ns = $urandom;
            if (i % 4 == 0) ns = 32'hFFFFFFFF - nonce_t'($urandom_range(0, 3));
            len = $urandom_range(0, 6);
            ne = ns + nonce_t'(len);
            tgt = rand_hash();
            tgt[255:224] = $urandom_range(0, 32'h3FFFFFFF);
            if (i % 5 == 0) tgt = '0;
            stub_mode = 2;
            stub_salt = $urandom;
            stub_lat  = $urandom_range(1, 20);
            model(ns, ne, tgt);
            do_sweep(rand_pfx(), ns, ne, tgt, (len + 1) * (stub_lat + 4) + 20);
            check_result($sformatf("r%0d", i), m_found, m_exh, m_att, m_rn, m_rh, ns);
        end

        // Short watchdog: no answer inside TIMEOUT, then a late sha_done is ignored.
        do_reset();
        stub_mode = 0;
        stub_const = '0;
        stub_lat = 30;
        start_both(rand_pfx(), 32'h1, 32'h1, '0);
        chk("to_s_begin", s_sha_begin, 1);
        wait_idle(1, 100, c);
        chk("to_s_busy_cycles", c, 1 + TO_SHORT);
        chk("to_s_flag", s_timeout_err, 1);
        repeat (25) @(negedge clk);
        chk("to_late_busy", s_busy, 0);
        chk("to_late_flag", s_timeout_err, 1);
        chk("to_late_rh", s_result_hash, 0);
        chk("to_late_att", s_attempts, 0);
        chk("to_late_found", s_found, 0);
        chk("to_main_exh", exhausted, 1);

        // sha_done in the last WAIT cycle wins over the watchdog.
        stub_const = 256'hABC;
        stub_lat = TO_SHORT;
        start_both(rand_pfx(), 32'h3, 32'h3, '1);
        wait_idle(1, 100, c);
        chk("edge_in_found", s_found, 1);
        chk("edge_in_to", s_timeout_err, 0);
        chk("edge_in_att", s_attempts, 1);
        repeat (5) @(negedge clk);

        // One cycle later the watchdog fires first.
        stub_lat = TO_SHORT + 1;
        start_both(rand_pfx(), 32'h3, 32'h3, '1);
        wait_idle(1, 100, c);
        chk("edge_out_to", s_timeout_err, 1);
        chk("edge_out_found", s_found, 0);
        chk("edge_out_att", s_attempts, 0);
        repeat (5) @(negedge clk);
        chk("edge_out_main_found", found, 1);

        // Default watchdog on the main instance, then a late completion.
        stub_lat = 1100;
        start_both(rand_pfx(), 32'h3, 32'h3, '1);
        wait_idle(0, 2000, c);
        chk("to_l_busy_cycles", c, 1 + TO_LONG);
        chk("to_l_flag", timeout_err, 1);
        repeat (100) @(negedge clk);
        chk("to_l_late_rh", result_hash, 256'hABC);
        chk("to_l_late_att", attempts, 0);
        chk("to_l_late_found", found, 0);
        chk("to_l_late_busy", busy, 0);

        // Abort in WAIT: completion arrives afterwards and must be ignored.
        stub_lat = 5;
        stub_const = 256'h1234;
        do_sweep(rand_pfx(), 32'h9, 32'h9, '1, 40);
        chk("ab_pre_rh", result_hash, 256'h1234);
        stub_const = 256'h5678;
        start_both(rand_pfx(), 32'h20, 32'h30, '0);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        nb = 0;
        for (int k = 0; k < 10; k++) begin
            if (sha_begin) nb++;
            @(negedge clk);
        end
        chk("ab_no_begin", nb, 0);
        chk("ab_rh", result_hash, 256'h1234);
        chk("ab_rn", result_nonce, 32'h9);
        chk("ab_att", attempts, 0);
        header_prefix = rand_pfx();
        nonce_start = 32'h40;
        nonce_end = 32'h40;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("ab_start_busy", busy, 0);
        chk("ab_start_begin", sha_begin, 0);
        repeat (3) @(negedge clk);
        chk("ab_start_busy2", busy, 0);

        // Reset asserted mid-WAIT clears everything immediately and stays cleared.
        stub_lat = 50;
        start_both(rand_pfx(), 32'h50, 32'h60, '1);
        repeat (5) @(negedge clk);
        chk("mid_busy", busy, 1);
        #2;
        n_rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        @(negedge clk);
        n_rst = 1'b0;
        repeat (60) @(negedge clk);
        chk_zero("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nonce_sweep_controller.md
Name: nonce_sweep_controller

Overview:
- Initiator side of the SHA computation interface.
- Holds a 408-bit block-header prefix and sweeps a 32-bit nonce over an inclusive range. For each nonce it builds the 440-bit message and pulses the SHA block's begin input.
- Waits for the completion pulse, then compares the returned 256-bit hash against a target.
- Stops on a hit, when the range is exhausted, on a watchdog timeout, or on abort. Sits between the miner top level and the SHA computation block.

Parameters:
- NONCE_W, 32, nonce width; message = {prefix, nonce}.
- MSG_W, 440, message width to SHA block.
- HASH_W, 256, hash and target width.
- TIMEOUT, 1024, max cycles in WAIT before timeout error.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous reset, active-high (1 = reset) despite name.
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  synchronous abort, any state.
- header_prefix  in  MSG_W-NONCE_W  message upper bits; captured at start.
- nonce_start  in  NONCE_W  first nonce; captured at start.
- nonce_end  in  NONCE_W  last nonce, inclusive; captured at start.
- target  in  HASH_W  hit threshold; captured at start.
- sha_msg  out  MSG_W  {prefix_q, nonce_q} to SHA block.
- sha_begin  out  1  one-cycle start pulse to SHA block.
- sha_done  in  1  one-cycle completion pulse from SHA block.
- sha_hash  in  HASH_W  hash; valid in the sha_done cycle.
- busy  out  1  high in LAUNCH, WAIT, CHECK.
- found  out  1  sticky; hit found.
- exhausted  out  1  sticky; range done, no hit.
- timeout_err  out  1  sticky; watchdog fired.
- result_nonce  out  NONCE_W  nonce of last checked hash.
- result_hash  out  HASH_W  last captured hash.
- attempts  out  32  hashes checked this sweep; saturates at 0xFFFFFFFF.

Behaviour:
- Reset: state IDLE. All outputs and captured registers are 0.
- States and transitions:
  - IDLE -> LAUNCH when start=1 and abort=0. This cycle captures prefix, start/end nonces and target, loads nonce_q=nonce_start, and clears found, exhausted, timeout_err and attempts.
  - LAUNCH: sha_begin=1 for exactly this one cycle. Watchdog cleared. Next state WAIT.
  - WAIT: watchdog counts each cycle.
    - sha_done=1 -> capture sha_hash into result_hash and nonce_q into result_nonce -> CHECK.
    - Watchdog reaches TIMEOUT-1 with no sha_done -> timeout_err=1 -> IDLE.
  - CHECK: attempts increments (saturating).
    - Hit -> found=1 -> IDLE.
    - Else nonce_q==nonce_end -> exhausted=1 -> IDLE.
    - Else nonce_q += 1 (mod 2^NONCE_W) -> LAUNCH.
- Hit rule: result_hash < target_q, unsigned, strict. target=0 never hits.
- Range:
  - Inclusive; nonce increments modulo 2^32.
  - nonce_start > nonce_end wraps through 0xFFFFFFFF -> 0.
  - nonce_start == nonce_end tests exactly one nonce.
- sha_msg is registered and stable from LAUNCH through WAIT. Nonce occupies sha_msg[NONCE_W-1:0].
- Per-nonce latency: 1 (LAUNCH) + SHA latency + 1 (CHECK). Sweep start: sha_begin rises 1 cycle after start is accepted.
- Ignored events:
  - sha_done outside WAIT, including a late completion after abort or timeout.
  - start while busy.
- Abort: in any state, forces IDLE next cycle. No sha_begin is issued. Sticky flags and result registers are retained. abort and start in the same cycle: abort wins and start is dropped.
- sha_done in the same cycle the watchdog expires: sha_done wins, so there is no timeout.
- Reset mid-sweep: immediate return to IDLE, everything cleared.

Decomposition:
- Package miner_pkg holds:
  - NONCE_W, MSG_W, HASH_W constants.
  - Typedef nonce_t.
  - Typedef hash_t.
  - Enum sweep_state_t {IDLE, LAUNCH, WAIT, CHECK}.
- One sub-module: hash_target_compare (combinational, hash_t a, hash_t b -> lt). It is reused later by a multi-core arbiter.

Test Plan (SHA block replaced by a stub with programmable latency and hash values):
- Prefix=408'h0, range 5..5, target all-ones, stub hash 0x00..01, latency 70 -> exactly one sha_begin; sha_msg low bits=5; found=1, result_nonce=5, attempts=1.
- Range 0x10..0x13, target=0 -> four sha_begin pulses with nonces 0x10, 0x11, 0x12, 0x13; exhausted=1, found=0, attempts=4.
- Range 0xFFFFFFFE..0x00000001, stub hits only on nonce 0x00000000 -> nonce order FFFFFFFE, FFFFFFFF, 00000000; found=1, result_nonce=0, attempts=3.
- TIMEOUT=16, stub never responds -> timeout_err=1 exactly 16 cycles after LAUNCH; busy=0. A later sha_done has no effect.
- Abort in WAIT, then stub sha_done 3 cycles later -> IDLE, result_hash unchanged, no further sha_begin. A following start with abort=1 in the same cycle is ignored.
- Reset asserted mid-WAIT -> all outputs 0 immediately, and they remain 0 after release until start.
